// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Two-requester write-port arbiter for a 4x16 register file
//               with a destination-register scoreboard. Define
//               RF_WARB_FIXED_PRIORITY_EN for fixed load-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Valid0,
    input  logic [AW-1:0]        Rd0,
    input  logic [DW-1:0]        Data0,
    output logic                 Ready0,
    input  logic                 Valid1,
    input  logic [AW-1:0]        Rd1,
    input  logic [DW-1:0]        Data1,
    output logic                 Ready1,
    input  logic                 Alloc,
    input  logic [AW-1:0]        AllocRd,
    output logic                 RegWrite,
    output logic [AW-1:0]        Rd,
    output logic [DW-1:0]        WriteData,
    output logic [(1<<AW)-1:0]   Busy
);

    logic grant0;
    logic grant1;
    logic [(1<<AW)-1:0] busy_next;

`ifdef RF_WARB_FIXED_PRIORITY_EN
    always_comb begin
        grant0 = Valid0 && !Valid1;
        grant1 = Valid1;
    end
`else
    // High when requester 1 took the most recent transfer.
    logic last_grant;

    always_comb begin
        grant0 = Valid0 && (!Valid1 || last_grant);
        grant1 = Valid1 && (!Valid0 || !last_grant);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            last_grant <= 1'b1;
        end else if (Ready0) begin
            last_grant <= 1'b0;
        end else if (Ready1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    assign Ready0 = Reset_n && grant0;
    assign Ready1 = Reset_n && grant1;

    // Set is applied after clear so a new allocation outlives a retiring write.
    always_comb begin
        busy_next = Busy;
        for (int i = 0; i < (1 << AW); i++) begin
            if (RegWrite && (Rd == AW'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (Alloc && (AllocRd == AW'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            Rd        <= '0;
            WriteData <= '0;
            Busy      <= '0;
        end else begin
            RegWrite <= Ready0 || Ready1;
            if (Ready1) begin
                Rd        <= Rd1;
                WriteData <= Data1;
            end else if (Ready0) begin
                Rd        <= Rd0;
                WriteData <= Data0;
            end
            Busy <= busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed scoreboard bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 2;
`ifdef RF_WARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic            Valid0, Valid1, Alloc;
    logic [AW-1:0]   Rd0, Rd1, AllocRd;
    logic [DW-1:0]   Data0, Data1;
    logic            Ready0, Ready1, RegWrite;
    logic [AW-1:0]   Rd;
    logic [DW-1:0]   WriteData;
    logic [3:0]      Busy;

    int compared   = 0;
    int mismatched = 0;
    logic [AW+DW-1:0] exp_q[$];

    regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Valid0(Valid0), .Rd0(Rd0), .Data0(Data0), .Ready0(Ready0),
        .Valid1(Valid1), .Rd1(Rd1), .Data1(Data1), .Ready1(Ready1),
        .Alloc(Alloc), .AllocRd(AllocRd),
        .RegWrite(RegWrite), .Rd(Rd), .WriteData(WriteData), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Check both readies shortly after inputs settle; queue the expected write.
    task automatic check_grant(input string name, input logic e0, input logic e1);
        #1;
        chk({name, "_ready0"}, {31'd0, Ready0}, {31'd0, e0});
        chk({name, "_ready1"}, {31'd0, Ready1}, {31'd0, e1});
        if (e1)      exp_q.push_back({Rd1, Data1});
        else if (e0) exp_q.push_back({Rd0, Data0});
    endtask

    // Monitor: every committed write must match the oldest expected transfer.
    always @(negedge Clock) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {30'd0, Rd, 1'b1}, 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_rd", {30'd0, Rd}, {30'd0, e[AW+DW-1:DW]});
                chk("wr_data", {16'd0, WriteData}, {16'd0, e[DW-1:0]});
            end
        end
    end

    initial begin
        Reset_n = 1'b0; Valid0 = 1'b1; Valid1 = 1'b1; Alloc = 1'b0;
        Rd0 = '0; Rd1 = '0; AllocRd = '0; Data0 = '0; Data1 = '0;

        // Reset held for two edges with both requesters asserting
        for (int i = 0; i < 2; i++) begin
            step();
            check_grant("reset", 1'b0, 1'b0);
        end
        chk("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("reset_busy", {28'd0, Busy}, 32'd0);
        Reset_n = 1'b1; Valid0 = 1'b0; Valid1 = 1'b0;
        step();
        chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);

        // Single write from requester 0
        Valid0 = 1'b1; Rd0 = 2'b01; Data0 = 16'd15;
        check_grant("single", 1'b1, 1'b0);
        step();
        Valid0 = 1'b0;
        chk("single_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("single_rd", {30'd0, Rd}, 32'd1);
        chk("single_data", {16'd0, WriteData}, 32'd15);
        step();
        chk("single_after", {31'd0, RegWrite}, 32'd0);

        // Scoreboard: alloc r2, load writes r2 three cycles later
        Alloc = 1'b1; AllocRd = 2'b10;
        step();
        Alloc = 1'b0;
        chk("sb_busy_a", {28'd0, Busy}, 32'h4);
        step();
        chk("sb_busy_b", {28'd0, Busy}, 32'h4);
        step();
        Valid1 = 1'b1; Rd1 = 2'b10; Data1 = 16'h00AB;
        check_grant("sb_write", 1'b0, 1'b1);
        step();
        Valid1 = 1'b0;
        chk("sb_busy_commit", {28'd0, Busy}, 32'h4);
        chk("sb_regwrite", {31'd0, RegWrite}, 32'd1);
        step();
        chk("sb_busy_clear", {28'd0, Busy}, 32'h0);

        // Contention: both held for four cycles
        Valid0 = 1'b1; Rd0 = 2'b10; Data0 = 16'd9;
        Valid1 = 1'b1; Rd1 = 2'b11; Data1 = 16'd7;
        for (int i = 0; i < 4; i++) begin
            logic g0;
            g0 = !FIXED && (i % 2 == 0);
            check_grant("contend", g0, !g0);
            step();
            chk("contend_regwrite", {31'd0, RegWrite}, 32'd1);
        end
        Valid0 = 1'b0; Valid1 = 1'b0;
        step();

        // Set wins over clear on the same bit
        Alloc = 1'b1; AllocRd = 2'b01;
        step();
        Alloc = 1'b0;
        Valid0 = 1'b1; Rd0 = 2'b01; Data0 = 16'h0055;
        check_grant("setwin_write", 1'b1, 1'b0);
        step();
        Valid0 = 1'b0;
        Alloc = 1'b1; AllocRd = 2'b01;
        chk("setwin_regwrite", {31'd0, RegWrite}, 32'd1);
        step();
        Alloc = 1'b0;
        chk("setwin_busy", {28'd0, Busy}, 32'h2);
        step();
        chk("setwin_hold", {28'd0, Busy}, 32'h2);

        // Reset mid-operation
        Valid0 = 1'b1; Rd0 = 2'b00; Data0 = 16'h1234;
        check_grant("pre_reset", 1'b1, 1'b0);
        step();
        Reset_n = 1'b0; Valid1 = 1'b1; Rd1 = 2'b11; Data1 = 16'h0BAD;
        check_grant("in_reset", 1'b0, 1'b0);
        step();
        chk("mid_reset_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("mid_reset_busy", {28'd0, Busy}, 32'h0);
        Reset_n = 1'b1; Data0 = 16'h4321;
        check_grant("post_reset", !FIXED, FIXED);
        step();
        Valid0 = 1'b0; Valid1 = 1'b0;
        step();
        step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port of the 4×16-bit register file between two writeback requesters: requester 0 (ALU result) and requester 1 (load/memory result).
- Registers the winning request and drives the register file's RegWrite / Rd / WriteData inputs.
- Keeps a 4-bit scoreboard of destination registers with an outstanding write, which decode uses to stall on read-after-write hazards.
- Sits between the execute/memory stages and Register_File.

## Interface
Parameters:
- DW, 16, data width (matches register file)
- AW, 2, register address width (4 registers)

Ports:
- Clock  input  1  single clock; all state updates on rising edge
- Reset_n  input  1  synchronous, active-low reset, sampled on rising edge of Clock
- Valid0  input  1  requester 0 has a write pending
- Rd0  input  AW  requester 0 destination register
- Data0  input  DW  requester 0 write data
- Ready0  output  1  requester 0 accepted this cycle (combinational)
- Valid1  input  1  requester 1 has a write pending
- Rd1  input  AW  requester 1 destination register
- Data1  input  DW  requester 1 write data
- Ready1  output  1  requester 1 accepted this cycle (combinational)
- Alloc  input  1  decode issued an instruction that will write AllocRd
- AllocRd  input  AW  destination being allocated
- RegWrite  output  1  register-file write enable (registered)
- Rd  output  AW  register-file write address (registered)
- WriteData  output  DW  register-file write data (registered)
- Busy  output  2**AW  scoreboard; bit i = register i has a pending write (registered)

## Operation
- Transfer on requester k: Validk && Readyk in the same cycle. At most one of Ready0/Ready1 is high in any cycle.
- Readyk is a combinational function of Valid0, Valid1 and the priority state only. It never depends on Rd/Data.
- Readyk is never high while Validk is low.
- Arbitration (round-robin):
  - Only one Valid high: that requester is granted.
  - Both Valid high: the requester not granted last is granted.
  - LastGrant updates only on a transfer.
  - Reset value of LastGrant = 1, so requester 0 wins the first contention.
- Output register, every edge:
  - RegWrite <= transfer occurred.
  - On a transfer: Rd/WriteData <= winner's Rd/Data.
  - No transfer: Rd/WriteData hold their values.
- A requester not granted must hold Valid/Rd/Data stable until accepted. The arbiter does not buffer losers.
- Scoreboard, per bit i, each edge:
  - Set when Alloc && AllocRd==i.
  - Cleared when RegWrite && Rd==i (the edge on which the register file commits the write).
  - Set and clear on the same bit in the same edge: set wins (newer producer).
- Reset (Reset_n low at an edge): RegWrite=0, Rd=0, WriteData=0, Busy=0, LastGrant=1.
  - Ready0/Ready1 are forced low while Reset_n is low.
  - Any in-flight request is dropped, not written.

## Timing
- Accept in cycle N → RegWrite=1 with the winner's Rd/WriteData during cycle N+1 → register file commits at the end of N+1.
- Latency: 1 cycle, request to write-port drive.
- Throughput: 1 write per cycle. Back-to-back transfers give RegWrite high continuously.
- Both Valid held high continuously: grants strictly alternate, 0,1,0,1…
- Busy bit for a register rises the edge after Alloc.
- Busy bit falls on the same edge the register file captures WriteData, so a decoder reading the register file when Busy is low sees committed data.

## Configuration
- RF_WARB_FIXED_PRIORITY_EN
  - Defined: requester 1 (load) always wins contention. LastGrant is not implemented and Ready0 = Valid0 && !Valid1.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: hold Reset_n=0 for 2 edges with Valid0=Valid1=1 → Ready0=Ready1=0; after release RegWrite=0, Busy=4'b0000.
- Single write: Valid0=1, Rd0=2'b01, Data0=16'd15 for one cycle → Ready0=1 that cycle; next cycle RegWrite=1, Rd=2'b01, WriteData=16'd15; the following cycle RegWrite=0.
- Contention: Valid0=1 (Rd0=2'b10, Data0=9) and Valid1=1 (Rd1=2'b11, Data1=7) held 4 cycles → grants 0,1,0,1; WriteData sequence 9,7,9,7 one cycle delayed.
- Scoreboard: Alloc with AllocRd=2'b10, then 3 cycles later Valid1 write to Rd 2'b10 → Busy=4'b0100 from the edge after Alloc until the edge RegWrite commits, then 4'b0000.
- Set-wins: Alloc AllocRd=2'b01 on the same edge RegWrite commits Rd=2'b01 → Busy[1] stays 1.
- Reset mid-operation: Reset_n=0 the cycle after a transfer → RegWrite=0, Busy=0 at the next edge; next contention grants requester 0 (with RF_WARB_FIXED_PRIORITY_EN defined: requester 1).
